// File: rtl/mem_stage.sv
// mem_stage: RISC-V load/store stage between ex_mem and mem_wb.
// Moves data over an 8-bit RAM bus one byte per cycle, little-endian,
// and stalls the pipeline until the access completes. Non-memory
// instructions pass straight through combinationally.
module mem_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  opcode_i,
  input  logic [2:0]  funct3_i,
  input  logic        we_i,
  input  logic [4:0]  waddr_i,
  input  logic [31:0] alu_i,
  input  logic [31:0] sdata_i,
  output logic [6:0]  opcode_o,
  output logic        we_o,
  output logic [4:0]  waddr_o,
  output logic [31:0] wdata_o,
  output logic        mem_req_o,
  input  logic        mem_grant_i,
  output logic [31:0] mem_a_o,
  output logic        mem_wr_o,
  output logic [7:0]  mem_dout_o,
  input  logic [7:0]  mem_din_i,
  output logic        stallreq_o
);

  localparam logic [6:0] LOAD_OPCODE  = 7'b0000011;
  localparam logic [6:0] STORE_OPCODE = 7'b0100011;

  typedef enum logic [1:0] {
    S_IDLE,
    S_GRANT_WAIT,
    S_ACCESS,
    S_DONE
  } state_t;

  state_t      r_state;
  logic [2:0]  r_cnt;
  logic [31:0] r_asm;

  logic        w_is_load;
  logic        w_is_store;
  logic        w_is_mem;
  logic        w_sext;
  logic [2:0]  w_nbytes;
  logic [2:0]  w_cnt_m1;
  logic        w_last;
  logic [7:0]  w_store_byte;
  logic [31:0] w_load_ext;

  assign w_is_load  = (opcode_i == LOAD_OPCODE);
  assign w_is_store = (opcode_i == STORE_OPCODE);
  assign w_is_mem   = w_is_load | w_is_store;
  assign w_sext     = ~funct3_i[2];

  // 00 -> byte, 01 -> half, 1x -> word
  assign w_nbytes = (funct3_i[1:0] == 2'b00) ? 3'd1 :
                    (funct3_i[1:0] == 2'b01) ? 3'd2 : 3'd4;

  // Loads need one extra ACCESS cycle because RAM data lags its address by one cycle.
  assign w_last   = w_is_load ? (r_cnt == w_nbytes) : (r_cnt == (w_nbytes - 3'd1));
  assign w_cnt_m1 = r_cnt - 3'd1;

  assign w_store_byte = sdata_i[{r_cnt[1:0], 3'b000} +: 8];

  // Sign- or zero-extend the assembled load bytes to 32 bits.
  always_comb begin
    // NOTE: every signal written in an always_comb gets a default first, so no path can leave it unassigned and infer a latch.
    w_load_ext = r_asm;
    case (funct3_i[1:0])
      2'b00:   w_load_ext = {{24{w_sext & r_asm[7]}},  r_asm[7:0]};
      2'b01:   w_load_ext = {{16{w_sext & r_asm[15]}}, r_asm[15:0]};
      default: w_load_ext = r_asm;
    endcase
  end

  // Access FSM: request, wait for grant, walk the bytes, then release the stall for one cycle.
  always_ff @(posedge clk) begin
    // NOTE: state uses non-blocking assignments so every register samples pre-edge values, independent of statement order.
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 3'd0;
      // NOTE: the assembly register is reset along with the FSM so a load abandoned by reset leaves no stale bytes visible.
      r_asm   <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_is_mem) begin
            r_cnt   <= 3'd0;
            r_state <= mem_grant_i ? S_ACCESS : S_GRANT_WAIT;
          end
        end
        S_GRANT_WAIT: begin
          if (!w_is_mem) begin
            r_state <= S_IDLE;
          end else if (mem_grant_i) begin
            r_cnt   <= 3'd0;
            r_state <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          if (!w_is_mem) begin
            r_state <= S_IDLE;
          end else begin
            if (w_is_load && (r_cnt != 3'd0)) begin
              r_asm[{w_cnt_m1[1:0], 3'b000} +: 8] <= mem_din_i;
            end
            r_cnt <= r_cnt + 3'd1;
            if (w_last) begin
              r_state <= S_DONE;
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Output decode: pass-through by default, bus and stall controls from the FSM state, all zero in reset.
  always_comb begin
    opcode_o   = 7'd0;
    we_o       = 1'b0;
    waddr_o    = 5'd0;
    wdata_o    = 32'd0;
    mem_req_o  = 1'b0;
    mem_a_o    = 32'd0;
    mem_wr_o   = 1'b0;
    mem_dout_o = 8'd0;
    stallreq_o = 1'b0;
    if (!rst) begin
      opcode_o = opcode_i;
      we_o     = we_i;
      waddr_o  = waddr_i;
      wdata_o  = alu_i;
      if (w_is_mem) begin
        case (r_state)
          S_IDLE, S_GRANT_WAIT: begin
            mem_req_o  = 1'b1;
            stallreq_o = 1'b1;
          end
          S_ACCESS: begin
            mem_req_o  = 1'b1;
            stallreq_o = 1'b1;
            mem_a_o    = alu_i + {29'd0, r_cnt};
            if (w_is_store) begin
              mem_wr_o   = 1'b1;
              mem_dout_o = w_store_byte;
            end
          end
          S_DONE: begin
            if (w_is_load) begin
              wdata_o = w_load_ext;
            end
          end
          default: begin
            mem_req_o  = 1'b0;
            stallreq_o = 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed and randomized checks of mem_stage against a
// byte-addressed reference memory and arithmetic load/store rules.
module tb_mem_stage;

  localparam logic [6:0] LOAD_OP  = 7'b0000011;
  localparam logic [6:0] STORE_OP = 7'b0100011;
  localparam logic [6:0] ALU_OP   = 7'b0110011;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  opcode_i;
  logic [2:0]  funct3_i;
  logic        we_i;
  logic [4:0]  waddr_i;
  logic [31:0] alu_i;
  logic [31:0] sdata_i;
  logic [6:0]  opcode_o;
  logic        we_o;
  logic [4:0]  waddr_o;
  logic [31:0] wdata_o;
  logic        mem_req_o;
  logic        mem_grant_i;
  logic [31:0] mem_a_o;
  logic        mem_wr_o;
  logic [7:0]  mem_dout_o;
  logic [7:0]  mem_din_i = 8'h00;
  logic        stallreq_o;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0] a;
    logic [7:0]  d;
  } wr_t;

  logic [7:0] ram     [logic [31:0]];
  logic [7:0] ref_mem [logic [31:0]];
  wr_t        wlog[$];

  mem_stage dut (
    .clk        (clk),
    .rst        (rst),
    .opcode_i   (opcode_i),
    .funct3_i   (funct3_i),
    .we_i       (we_i),
    .waddr_i    (waddr_i),
    .alu_i      (alu_i),
    .sdata_i    (sdata_i),
    .opcode_o   (opcode_o),
    .we_o       (we_o),
    .waddr_o    (waddr_o),
    .wdata_o    (wdata_o),
    .mem_req_o  (mem_req_o),
    .mem_grant_i(mem_grant_i),
    .mem_a_o    (mem_a_o),
    .mem_wr_o   (mem_wr_o),
    .mem_dout_o (mem_dout_o),
    .mem_din_i  (mem_din_i),
    .stallreq_o (stallreq_o)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] seed_byte(input logic [31:0] a);
    return a[7:0] ^ a[23:16] ^ 8'h5A;
  endfunction

  function automatic logic [7:0] ram_rd(input logic [31:0] a);
    return ram.exists(a) ? ram[a] : seed_byte(a);
  endfunction

  function automatic logic [7:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : seed_byte(a);
  endfunction

  // RAM responder: writes on strobe, read data one cycle after its address.
  always @(posedge clk) begin
    if (mem_wr_o) begin
      ram[mem_a_o] = mem_dout_o;
      wlog.push_back('{a: mem_a_o, d: mem_dout_o});
    end
    mem_din_i <= ram_rd(mem_a_o);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic poke(input logic [31:0] a, input logic [7:0] d);
    ram[a]     = d;
    ref_mem[a] = d;
  endtask

  // Present a non-memory instruction for one cycle; result is same-cycle.
  task automatic run_pt(input logic [6:0] op, input logic [31:0] a, input logic we, input logic [4:0] wa);
    opcode_i    = op;
    funct3_i    = 3'($urandom_range(0, 7));
    we_i        = we;
    waddr_i     = wa;
    alu_i       = a;
    sdata_i     = $urandom;
    mem_grant_i = 1'b0;
    #1;
    check("pt_wdata", wdata_o, a);
    check("pt_ctrl", {25'd0, opcode_o, we_o, waddr_o, stallreq_o, mem_req_o, mem_wr_o},
                     {25'd0, op, we, wa, 3'b000});
    @(posedge clk);
    @(negedge clk);
  endtask

  // Run one load/store with the grant withheld for w cycles; called and returns at a negedge.
  task automatic run_op(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] sd, input logic [4:0] wa, input int w);
    int          n;
    int          exp_stall;
    int          stall_cnt;
    int          cyc;
    bit          done;
    bit          is_load;
    logic [31:0] exp_wd;
    is_load = (op == LOAD_OP);
    n       = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    if (is_load) begin
      exp_wd = 32'd0;
      for (int i = 0; i < n; i++) exp_wd = exp_wd | (32'(ref_rd(a + 32'(i))) << (8 * i));
      if (!f3[2] && n < 4 && exp_wd[8*n-1]) exp_wd = exp_wd - (32'd1 << (8 * n));
      exp_stall = n + 2 + w;
    end else begin
      exp_wd    = a;
      exp_stall = n + 1 + w;
    end
    opcode_i    = op;
    funct3_i    = f3;
    we_i        = is_load;
    waddr_i     = wa;
    alu_i       = a;
    sdata_i     = sd;
    mem_grant_i = (w == 0);
    wlog.delete();
    stall_cnt = 0;
    done      = 1'b0;
    for (cyc = 0; cyc < 40 && !done; cyc++) begin
      #1;
      if (stallreq_o) begin
        stall_cnt++;
        check("req_with_stall", {31'd0, mem_req_o}, 32'd1);
        if (is_load && cyc > w && cyc <= w + n)
          check("load_addr", mem_a_o, a + 32'(cyc - w - 1));
      end else begin
        done = 1'b1;
        check("stall_cycles", 32'(stall_cnt), 32'(exp_stall));
        check("wdata", wdata_o, exp_wd);
        check("done_ctrl", {25'd0, opcode_o, we_o, waddr_o, mem_req_o, mem_wr_o},
                           {25'd0, op, is_load, wa, 2'b00});
      end
      if (!done) begin
        @(posedge clk);
        @(negedge clk);
        mem_grant_i = ((cyc + 1) >= w);
      end
    end
    if (!done) check("timeout_stall", 32'(stall_cnt), 32'(exp_stall));
    check("wr_count", 32'(wlog.size()), is_load ? 32'd0 : 32'(n));
    if (!is_load) begin
      for (int i = 0; i < n && i < wlog.size(); i++) begin
        check("wr_addr", wlog[i].a, a + 32'(i));
        check("wr_byte", {24'd0, wlog[i].d}, {24'd0, 8'(sd >> (8 * i))});
      end
      for (int i = 0; i < n; i++) ref_mem[a + 32'(i)] = 8'(sd >> (8 * i));
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst         = 1'b1;
    opcode_i    = LOAD_OP;
    funct3_i    = 3'b010;
    we_i        = 1'b1;
    waddr_i     = 5'd7;
    alu_i       = 32'h0000_1234;
    sdata_i     = 32'hDEAD_BEEF;
    mem_grant_i = 1'b1;

    // Reset: every output held at zero
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      #1;
      check("rst_wdata", wdata_o, 32'd0);
      check("rst_addr", mem_a_o, 32'd0);
      check("rst_ctrl", {8'd0, opcode_o, we_o, waddr_o, mem_req_o, mem_wr_o, mem_dout_o, stallreq_o}, 32'd0);
    end
    @(negedge clk);
    rst = 1'b0;

    // Pass-through
    run_pt(ALU_OP, 32'h0000_1234, 1'b1, 5'd5);

    // LW 0x100 = 0x12345678, grant tied high
    poke(32'h100, 8'h78);
    poke(32'h101, 8'h56);
    poke(32'h102, 8'h34);
    poke(32'h103, 8'h12);
    run_op(LOAD_OP, 3'b010, 32'h100, 32'd0, 5'd3, 0);

    // LB / LBU of 0x80
    poke(32'h7, 8'h80);
    run_op(LOAD_OP, 3'b000, 32'h7, 32'd0, 5'd4, 0);
    run_op(LOAD_OP, 3'b100, 32'h7, 32'd0, 5'd4, 0);

    // LH wrapping from 0xFFFFFFFF to 0x0
    poke(32'hFFFF_FFFF, 8'h34);
    poke(32'h0, 8'h92);
    run_op(LOAD_OP, 3'b001, 32'hFFFF_FFFF, 32'd0, 5'd6, 0);

    // SH misaligned, then read it back
    run_op(STORE_OP, 3'b001, 32'h201, 32'hAABB_CCDD, 5'd0, 0);
    run_op(LOAD_OP, 3'b101, 32'h201, 32'd0, 5'd8, 0);

    // SW with grant withheld 3 cycles, then read back with a wait
    run_op(STORE_OP, 3'b010, 32'h300, 32'hCAFE_F00D, 5'd0, 3);
    run_op(LOAD_OP, 3'b010, 32'h300, 32'd0, 5'd9, 2);

    // Reset during the 2nd byte of an LW, then the same LW restarts
    opcode_i    = LOAD_OP;
    funct3_i    = 3'b010;
    we_i        = 1'b1;
    waddr_i     = 5'd10;
    alu_i       = 32'h100;
    mem_grant_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_wdata", wdata_o, 32'd0);
    check("midrst_addr", mem_a_o, 32'd0);
    check("midrst_ctrl", {8'd0, opcode_o, we_o, waddr_o, mem_req_o, mem_wr_o, mem_dout_o, stallreq_o}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    run_op(LOAD_OP, 3'b010, 32'h100, 32'd0, 5'd10, 0);

    // Randomized mix of loads, stores and pass-through
    for (int it = 0; it < 60; it++) begin
      logic [31:0] ra;
      int          sel;
      sel = $urandom_range(0, 2);
      ra  = ($urandom_range(0, 1) == 1) ? 32'h400 + 32'($urandom_range(0, 31))
                                        : 32'hFFFF_FFF8 + 32'($urandom_range(0, 7));
      case (sel)
        0: run_op(LOAD_OP, 3'($urandom_range(0, 7)), ra, 32'd0, 5'($urandom_range(1, 31)),
                  $urandom_range(0, 3));
        1: run_op(STORE_OP, 3'($urandom_range(0, 7)), ra, $urandom, 5'd0, $urandom_range(0, 3));
        default: run_pt(ALU_OP, $urandom, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)));
      endcase
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage between the ex_mem and mem_wb pipeline registers. It performs RISC-V loads and stores over the 8-bit external RAM bus, one byte per cycle, and holds the pipeline through stallctrl while an access is in flight. Its combinational result outputs drive mem_wb and the register file's mem-stage forwarding inputs (we, waddr, wdata, opcode).

## Interface
- LOAD_OPCODE, 7'b0000011, opcode that selects a load
- STORE_OPCODE, 7'b0100011, opcode that selects a store
- clk  in  1  the single clock; all state changes on its rising edge
- rst  in  1  synchronous, active-high reset
- opcode_i  in  7  instruction opcode from ex_mem
- funct3_i  in  3  access size and sign selection from ex_mem
- we_i  in  1  register write enable from ex_mem
- waddr_i  in  5  destination register from ex_mem
- alu_i  in  32  ALU result; this is the byte address for loads and stores
- sdata_i  in  32  store data (rs2 value)
- opcode_o  out  7  opcode passed to mem_wb and regfile
- we_o  out  1  write enable to mem_wb and regfile
- waddr_o  out  5  destination register
- wdata_o  out  32  write-back data
- mem_req_o  out  1  bus request to the fetch/mem arbiter
- mem_grant_i  in  1  bus grant from the arbiter
- mem_a_o  out  32  RAM byte address
- mem_wr_o  out  1  RAM write strobe (1 = write)
- mem_dout_o  out  8  RAM write byte
- mem_din_i  in  8  RAM read byte; valid one cycle after its address
- stallreq_o  out  1  stall request to stallctrl

## Operation
- Byte count N comes from funct3_i[1:0]: 00 gives 1, 01 gives 2, 10 and 11 give 4. Sign extension applies when funct3_i[2] = 0 (loads only). Byte order is little-endian.
- Any opcode other than LOAD or STORE passes straight through: opcode_o, we_o and waddr_o equal the inputs, wdata_o = alu_i, stallreq_o = 0, mem_req_o = 0. This path is purely combinational.
- The FSM has four states: IDLE, GRANT_WAIT, ACCESS and DONE. The byte counter cnt is 3 bits; the assembly register asm holds 32 bits.
- IDLE:
  - If a load or store is present, mem_req_o = 1 and stallreq_o = 1.
  - If mem_grant_i = 1, go to ACCESS with cnt = 0. Otherwise go to GRANT_WAIT.
- GRANT_WAIT: mem_req_o = 1 and stallreq_o = 1. Go to ACCESS with cnt = 0 on the first cycle mem_grant_i = 1.
- ACCESS: mem_req_o = 1 and stallreq_o = 1.
  - Address: mem_a_o = alu_i + cnt, modulo 2^32. Wrap from 0xFFFFFFFF to 0 is legal.
  - Store: mem_wr_o = 1 and mem_dout_o = sdata_i[8cnt+7:8cnt]. Increment cnt each cycle. After the cycle with cnt = N-1, go to DONE.
  - Load: mem_wr_o = 0. When cnt >= 1, capture mem_din_i into asm byte cnt-1. Increment cnt each cycle. After the cycle with cnt = N, go to DONE. The address emitted on that last cycle is don't-care, but mem_wr_o stays 0.
- DONE:
  - mem_req_o = 0 and stallreq_o = 0, so the pipeline advances on this edge.
  - Load: wdata_o is asm with its N bytes sign- or zero-extended.
  - Store: wdata_o = alu_i.
  - Always go to IDLE next.
- The arbiter never revokes mem_grant_i while mem_req_o is high. mem_grant_i is sampled only in IDLE and GRANT_WAIT.
- In DONE, opcode_o, we_o and waddr_o still reflect the ex_mem inputs. The register file's own load-forwarding stall for that cycle is expected and harmless.
- Misaligned addresses are legal and are handled byte by byte.

## Timing
- Outputs while rst = 1: every output is 0. This covers the result bus, mem_req_o, mem_wr_o, mem_a_o, mem_dout_o and stallreq_o.
- State on the rst edge: state goes to IDLE, and cnt and asm go to 0. A reset mid-access abandons the access. Bytes already written stay written.
- Load latency, grant present in IDLE: 1 IDLE cycle + (N+1) ACCESS cycles, then DONE on cycle N+2. stallreq_o is high for N+2 cycles.
- Store latency, grant present in IDLE: 1 IDLE cycle + N ACCESS cycles, then DONE on cycle N+1.
- Each cycle spent in GRANT_WAIT adds exactly one cycle to either latency.
- RAM read model: the byte at mem_a_o in cycle t appears on mem_din_i in cycle t+1.
- Back-to-back memory ops: after DONE the FSM is in IDLE with the next instruction already presented, so there is no idle bubble.

## Test plan
- Pass-through: opcode 0110011, alu_i = 0x1234, we_i = 1, waddr 5 -> same cycle: wdata_o = 0x1234, we_o = 1, stallreq_o = 0, mem_req_o = 0.
- LW at 0x100 with RAM[0x100..0x103] = 78 56 34 12, grant tied high:
  - mem_a_o walks 0x100 to 0x103 during ACCESS.
  - wdata_o = 0x12345678 in DONE on cycle 6.
  - stallreq_o is high for exactly 6 cycles.
- LB and LBU at 0x7 with RAM[0x7] = 0x80 -> wdata_o = 0xFFFFFF80 for LB and 0x00000080 for LBU. LH at 0xFFFFFFFF reads bytes at 0xFFFFFFFF then 0x0.
- SH at 0x201, sdata_i = 0xAABBCCDD -> two write cycles: (0x201, 0xDD) then (0x202, 0xCC). No third strobe.
- Grant held low for 3 cycles on an SW -> mem_req_o is high throughout. The write strobes start only after grant, and total stall is 3 cycles longer than the no-wait case.
- rst asserted during the 2nd byte of an LW -> all outputs are 0 while rst = 1. The next cycle starts in IDLE and the same LW restarts from byte 0.
